// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: FSM state encoding for the frame generator
// and default widths reused across the stream blocks.
package axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } gen_state_e;

    localparam int AXIS_TDATA_W_DEF = 32;
    localparam int AXIS_LEN_W_DEF   = 16;
    localparam int AXIS_CNT_W_DEF   = 16;
    localparam int AXIS_GAP_W_DEF   = 8;

endpackage

// File: rtl/axis_frame_gen.sv
// AXI-Stream master producing a configurable number of frames of incrementing
// data, with optional idle gaps between frames. All stream outputs are registered.
module axis_frame_gen
    import axis_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = AXIS_TDATA_W_DEF,
    parameter int LEN_WIDTH            = AXIS_LEN_W_DEF,
    parameter int CNT_WIDTH            = AXIS_CNT_W_DEF,
    parameter int GAP_WIDTH            = AXIS_GAP_W_DEF
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic [LEN_WIDTH-1:0]            cfg_len,
    input  logic [CNT_WIDTH-1:0]            cfg_frames,
    input  logic [GAP_WIDTH-1:0]            cfg_gap,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0] cfg_seed,
    output logic                            m_axis_tvalid,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic                            busy,
    output logic                            done
);

    localparam logic [LEN_WIDTH-1:0]            LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]            CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0]            GAP_ONE  = GAP_WIDTH'(1);
    localparam logic [C_M_AXIS_TDATA_WIDTH-1:0] DATA_ONE = C_M_AXIS_TDATA_WIDTH'(1);

    gen_state_e                      state_q, state_d;
    logic [LEN_WIDTH-1:0]            len_q, len_d;
    logic [CNT_WIDTH-1:0]            frames_q, frames_d;
    logic [GAP_WIDTH-1:0]            gap_q, gap_d;
    logic [LEN_WIDTH-1:0]            beat_idx_q, beat_idx_d;
    logic [CNT_WIDTH-1:0]            frame_idx_q, frame_idx_d;
    logic [GAP_WIDTH-1:0]            gap_cnt_q, gap_cnt_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                            tvalid_q, tvalid_d;
    logic                            tlast_q, tlast_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic                            beat_fire;
    logic [LEN_WIDTH-1:0]            beat_nxt;

    assign beat_fire = tvalid_q && m_axis_tready;
    assign beat_nxt  = beat_idx_q + LEN_ONE;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        frames_d    = frames_q;
        gap_d       = gap_q;
        beat_idx_d  = beat_idx_q;
        frame_idx_d = frame_idx_q;
        gap_cnt_d   = gap_cnt_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A zero length is promoted to one so len_q-1 never underflows.
                    len_d       = (cfg_len == '0) ? LEN_ONE : cfg_len;
                    frames_d    = cfg_frames;
                    gap_d       = cfg_gap;
                    beat_idx_d  = '0;
                    frame_idx_d = '0;
                    tdata_d     = cfg_seed;
                    if (cfg_frames == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_SEND;
                        tvalid_d = 1'b1;
                        tlast_d  = (cfg_len <= LEN_ONE);
                    end
                end
            end

            ST_SEND: begin
                if (beat_fire) begin
                    tdata_d = tdata_q + DATA_ONE;
                    if (tlast_q) begin
                        beat_idx_d  = '0;
                        frame_idx_d = frame_idx_q + CNT_ONE;
                        if (frame_idx_q == frames_q - CNT_ONE) begin
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            state_d  = ST_DONE;
                        end else if (gap_q != '0) begin
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            gap_cnt_d = gap_q;
                            state_d   = ST_GAP;
                        end else begin
                            tvalid_d = 1'b1;
                            tlast_d  = (len_q == LEN_ONE);
                        end
                    end else begin
                        beat_idx_d = beat_nxt;
                        tlast_d    = (beat_nxt == len_q - LEN_ONE);
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_ONE) begin
                    gap_cnt_d = '0;
                    tvalid_d  = 1'b1;
                    tlast_d   = (len_q == LEN_ONE);
                    state_d   = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_SEND) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            frames_q    <= '0;
            gap_q       <= '0;
            beat_idx_q  <= '0;
            frame_idx_q <= '0;
            gap_cnt_q   <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            frames_q    <= frames_d;
            gap_q       <= gap_d;
            beat_idx_q  <= beat_idx_d;
            frame_idx_q <= frame_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: each scenario drives a run and checks
// every beat, gap cycle and done pulse against hand-computed values.
module tb_axis_frame_gen;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [15:0] cfg_len;
    logic [15:0] cfg_frames;
    logic [7:0]  cfg_gap;
    logic [31:0] cfg_seed;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    axis_frame_gen #(
        .C_M_AXIS_TDATA_WIDTH(32),
        .LEN_WIDTH(16),
        .CNT_WIDTH(16),
        .GAP_WIDTH(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .cfg_len(cfg_len),
        .cfg_frames(cfg_frames),
        .cfg_gap(cfg_gap),
        .cfg_seed(cfg_seed),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] len, input logic [15:0] frames,
                          input logic [7:0] gap, input logic [31:0] seed);
        cfg_len    = len;
        cfg_frames = frames;
        cfg_gap    = gap;
        cfg_seed   = seed;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        cfg_len    = 16'hDEAD;
        cfg_frames = 16'h00FF;
        cfg_gap    = 8'h77;
        cfg_seed   = 32'hBAD0BAD0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start = 1'b0;
        m_axis_tready = 1'b1;
        cfg_len = '0; cfg_frames = '0; cfg_gap = '0; cfg_seed = '0;
        tick();
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_stream: got v=%b l=%b d=%h required v=0 l=0 d=0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b done=%b required 0 0", busy, done);
        end
        #2 rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        launch(16'd4, 16'd2, 8'd0, 32'h10);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b required 1", busy);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h10 + 32'(i) ||
                m_axis_tlast !== ((i % 4) == 3)) begin
                errors++;
                $display("FAIL basic_beat%0d: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, 32'h10 + 32'(i), (i % 4) == 3);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%b v=%b busy=%b required 1 0 0", done, m_axis_tvalid, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got %b required 0", done);
        end
    endtask

    task automatic test_gap();
        launch(16'd3, 16'd2, 8'd2, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(i) || m_axis_tlast !== (i == 2)) begin
                errors++;
                $display("FAIL gap_beat%0d: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, 32'(i), i == 2);
            end
            tick();
        end
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (m_axis_tvalid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL gap_idle%0d: got v=%b busy=%b required v=0 busy=1", g, m_axis_tvalid, busy);
            end
            tick();
        end
        for (int i = 3; i < 6; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(i) || m_axis_tlast !== (i == 5)) begin
                errors++;
                $display("FAIL gap_beat%0d: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, 32'(i), i == 5);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL gap_done: got done=%b v=%b required 1 0", done, m_axis_tvalid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        launch(16'd5, 16'd1, 8'd0, 32'hA0);
        while (idx < 5 && cyc < 40) begin
            m_axis_tready = ((cyc % 3) == 0);
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA0 + 32'(idx) ||
                m_axis_tlast !== (idx == 4)) begin
                errors++;
                $display("FAIL bp_cycle%0d: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                         cyc, m_axis_tvalid, m_axis_tdata, m_axis_tlast, 32'hA0 + 32'(idx), idx == 4);
            end
            if (m_axis_tready) idx++;
            cyc++;
            tick();
        end
        m_axis_tready = 1'b1;
        checks++;
        if (idx != 5 || done !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: got beats=%0d done=%b v=%b required 5 1 0", idx, done, m_axis_tvalid);
        end
        tick();
    endtask

    task automatic test_empty_and_len0();
        launch(16'd4, 16'd0, 8'd0, 32'h1234);
        checks++;
        if (done !== 1'b1 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: got done=%b v=%b busy=%b required 1 0 0", done, m_axis_tvalid, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL empty_after: got done=%b v=%b required 0 0", done, m_axis_tvalid);
        end
        launch(16'd0, 16'd3, 8'd0, 32'h40);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h40 + 32'(i) || m_axis_tlast !== 1'b1) begin
                errors++;
                $display("FAIL len0_beat%0d: got v=%b d=%h l=%b required v=1 d=%h l=1",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, 32'h40 + 32'(i));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL len0_done: got %b required 1", done);
        end
        tick();
    endtask

    task automatic test_wrap_and_ignored_start();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'hFFFFFFFE; exp_d[1] = 32'hFFFFFFFF; exp_d[2] = 32'h0; exp_d[3] = 32'h1;
        launch(16'd4, 16'd1, 8'd0, 32'hFFFFFFFE);
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[i] || m_axis_tlast !== (i == 3)) begin
                errors++;
                $display("FAIL wrap_beat%0d: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_d[i], i == 3);
            end
            tick();
        end
        start = 1'b1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: got %b required 1", done);
        end
        tick();
        start = 1'b0;
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: got v=%b busy=%b done=%b required 0 0 0",
                     m_axis_tvalid, busy, done);
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        m_axis_tready = 1'b0;
        launch(16'd1, 16'd2, 8'd0, 32'h55);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got v=%b l=%b required 1 1", m_axis_tvalid, m_axis_tlast);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got v=%b l=%b busy=%b required 0 0 0", m_axis_tvalid, m_axis_tlast, busy);
        end
        tick();
        #2 rstn = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        launch(16'd2, 16'd1, 8'd0, 32'h200);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h200 + 32'(i) || m_axis_tlast !== (i == 1)) begin
                errors++;
                $display("FAIL rst_fresh%0d: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, 32'h200 + 32'(i), i == 1);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_fresh_done: got done=%b v=%b required 1 0", done, m_axis_tvalid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_backpressure();
        test_empty_and_len0();
        test_wrap_and_ignored_start();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
